// File: rtl/tug_of_war_pkg.sv
// Shared types for the tug-of-war round controller: controller states and
// the winner encodings driven onto the display.
package tug_of_war_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    POINT = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/tug_of_war_key_press.sv
// Rising-edge detector for one player key. The history register resets high
// so a key held through reset is not seen as a fresh press.
module key_press (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic press
);

  logic prev_q;

  // Key history, sampled every cycle regardless of controller state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= key;
    end
  end

  assign press = key & ~prev_q;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Round controller: moves the lit position on accepted presses, scores pulls
// past either end, holds the point display, then recentres; OVER is terminal.
module tug_of_war_ctrl
  import tug_of_war_pkg::*;
#(
  parameter int NUM_LIGHTS     = 9,
  parameter int SCORE_MAX      = 7,
  parameter int RESTART_CYCLES = 4
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             L,
  input  logic                             R,
  output logic [NUM_LIGHTS-1:0]            lights,
  output logic [$clog2(SCORE_MAX+1)-1:0]   scoreL,
  output logic [$clog2(SCORE_MAX+1)-1:0]   scoreR,
  output logic [1:0]                       winner,
  output logic                             gameOver
);

  localparam int SW = $clog2(SCORE_MAX + 1);
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [PW-1:0] POS_CENTRE = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] POS_LEFT   = PW'(NUM_LIGHTS - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(RESTART_CYCLES - 1);
  localparam logic [SW-1:0] SCORE_WIN  = SW'(SCORE_MAX);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_LSB = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};

  logic press_l, press_r, move_l, move_r;

  state_e                  state_q, state_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]              winner_q, winner_d;
  logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
  logic                    game_over_q, game_over_d;

  key_press u_key_l (.Clock(Clock), .Reset(Reset), .key(L), .press(press_l));
  key_press u_key_r (.Clock(Clock), .Reset(Reset), .key(R), .press(press_r));

  // A simultaneous press cancels out rather than favouring either side.
  assign move_l = press_l & ~press_r;
  assign move_r = press_r & ~press_l;

  // Next-state logic; the light bus and gameOver are derived from the next
  // state so that they come straight out of registers.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    case (state_q)
      PLAY: begin
        if (move_l) begin
          if (pos_q == POS_LEFT) begin
            score_l_d = score_l_q + SW'(1);
            winner_d  = WIN_LEFT;
            cnt_d     = '0;
            state_d   = (score_l_d == SCORE_WIN) ? OVER : POINT;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (move_r) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + SW'(1);
            winner_d  = WIN_RIGHT;
            cnt_d     = '0;
            state_d   = (score_r_d == SCORE_WIN) ? OVER : POINT;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end else begin
          pos_d = pos_q;
        end
      end
      POINT: begin
        if (cnt_q == CNT_LAST) begin
          pos_d    = POS_CENTRE;
          winner_d = WIN_NONE;
          cnt_d    = '0;
          state_d  = PLAY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_CENTRE;
      end
    endcase
    lights_d    = (state_d == PLAY) ? (LIGHT_LSB << pos_d) : '0;
    game_over_d = (state_d == OVER);
  end

  // Controller state and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= PLAY;
      pos_q       <= POS_CENTRE;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      lights_q    <= LIGHT_LSB << POS_CENTRE;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      lights_q    <= lights_d;
      game_over_q <= game_over_d;
    end
  end

  assign lights   = lights_q;
  assign scoreL   = score_l_q;
  assign scoreR   = score_r_q;
  assign winner   = winner_q;
  assign gameOver = game_over_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Self-checking bench for tug_of_war_ctrl: a vector table plus hand-written
// sequences for scoring, game over and asynchronous reset.
module tb_tug_of_war_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic [8:0] lights;
  logic [2:0] scoreL, scoreR;
  logic [1:0] winner;
  logic       gameOver;

  typedef struct packed {
    logic [8:0] lights;
    logic [2:0] sl;
    logic [2:0] sr;
    logic [1:0] w;
    logic       go;
  } out_t;

  typedef struct packed {
    logic l;
    logic r;
    out_t exp;
  } vec_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[29];

  tug_of_war_ctrl #(.NUM_LIGHTS(9), .SCORE_MAX(7), .RESTART_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .L(L), .R(R),
    .lights(lights), .scoreL(scoreL), .scoreR(scoreR),
    .winner(winner), .gameOver(gameOver)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  function automatic out_t mk(input logic [8:0] li, input logic [2:0] sl,
                              input logic [2:0] sr, input logic [1:0] w, input logic go);
    out_t o;
    o.lights = li; o.sl = sl; o.sr = sr; o.w = w; o.go = go;
    return o;
  endfunction

  task automatic compare(input string name, input out_t exp);
    out_t got;
    got = '{lights: lights, sl: scoreL, sr: scoreR, w: winner, go: gameOver};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got lights=%b sL=%0d sR=%0d w=%b go=%b, want lights=%b sL=%0d sR=%0d w=%b go=%b",
               name, got.lights, got.sl, got.sr, got.w, got.go,
               exp.lights, exp.sl, exp.sr, exp.w, exp.go);
    end
  endtask

  // Drive keys, queue the expectation, clock once and check just after the edge.
  task automatic step(input string name, input logic l, input logic r, input out_t exp);
    out_t e;
    L = l;
    R = r;
    exp_q.push_back(exp);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    compare(name, e);
  endtask

  task automatic async_reset(input string name);
    #3 Reset = 1'b1;
    #1 compare(name, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    #1 Reset = 1'b0;
  endtask

  initial begin
    int pos_m;
    logic [2:0] sr_m;

    tbl[0]  = '{1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1'b1, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[6]  = '{1'b0, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[7]  = '{1'b0, 1'b1, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[8]  = '{1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[9]  = '{1'b1, 1'b1, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[10] = '{1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[11] = '{1'b1, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[12] = '{1'b1, 1'b1, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[13] = '{1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[14] = '{1'b1, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[15] = '{1'b0, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[16] = '{1'b1, 1'b0, mk(9'h040, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[17] = '{1'b0, 1'b0, mk(9'h040, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[18] = '{1'b1, 1'b0, mk(9'h080, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[19] = '{1'b0, 1'b0, mk(9'h080, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[20] = '{1'b1, 1'b0, mk(9'h100, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[21] = '{1'b0, 1'b0, mk(9'h100, 3'd0, 3'd0, 2'b00, 1'b0)};
    tbl[22] = '{1'b1, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0)};
    tbl[23] = '{1'b0, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0)};
    tbl[24] = '{1'b1, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0)};
    tbl[25] = '{1'b0, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0)};
    tbl[26] = '{1'b0, 1'b1, mk(9'h010, 3'd1, 3'd0, 2'b00, 1'b0)};
    tbl[27] = '{1'b1, 1'b1, mk(9'h020, 3'd1, 3'd0, 2'b00, 1'b0)};
    tbl[28] = '{1'b0, 1'b0, mk(9'h020, 3'd1, 3'd0, 2'b00, 1'b0)};

    // Reset must take effect without any clock edge.
    #2 Reset = 1'b1;
    #1 compare("reset", mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 29; i++) step($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, tbl[i].exp);

    // Right player takes seven points from the current position.
    pos_m = 5;
    sr_m  = 3'd0;
    for (int p = 1; p <= 7; p++) begin
      while (pos_m > 0) begin
        pos_m--;
        step("r_move", 1'b0, 1'b1, mk(9'(32'd1 << pos_m), 3'd1, sr_m, 2'b00, 1'b0));
        step("r_rel", 1'b0, 1'b0, mk(9'(32'd1 << pos_m), 3'd1, sr_m, 2'b00, 1'b0));
      end
      sr_m = sr_m + 3'd1;
      if (p < 7) begin
        step("r_score", 1'b0, 1'b1, mk(9'h000, 3'd1, sr_m, 2'b01, 1'b0));
        for (int h = 0; h < 3; h++) step("r_hold", 1'b0, 1'b0, mk(9'h000, 3'd1, sr_m, 2'b01, 1'b0));
        step("r_recentre", 1'b0, 1'b0, mk(9'h010, 3'd1, sr_m, 2'b00, 1'b0));
        pos_m = 4;
      end else begin
        step("game_over", 1'b0, 1'b1, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
      end
    end
    step("over_hold0", 1'b1, 1'b0, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
    step("over_hold1", 1'b0, 1'b0, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
    step("over_hold2", 1'b0, 1'b1, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
    step("over_hold3", 1'b0, 1'b0, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
    step("over_hold4", 1'b1, 1'b1, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));
    step("over_hold5", 1'b0, 1'b0, mk(9'h000, 3'd1, 3'd7, 2'b01, 1'b1));

    async_reset("reset_from_over");
    step("post_reset", 1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));

    // Reach POINT again, then reset mid-hold with L held across release.
    for (int i = 1; i <= 4; i++) begin
      step("l_move", 1'b1, 1'b0, mk(9'(32'h10 << i), 3'd0, 3'd0, 2'b00, 1'b0));
      step("l_rel", 1'b0, 1'b0, mk(9'(32'h10 << i), 3'd0, 3'd0, 2'b00, 1'b0));
    end
    step("l_score", 1'b1, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0));
    step("l_hold", 1'b0, 1'b0, mk(9'h000, 3'd1, 3'd0, 2'b10, 1'b0));
    L = 1'b1;
    async_reset("reset_mid_point");
    for (int i = 0; i < 3; i++) step("held_after_reset", 1'b1, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    step("held_release", 1'b0, 1'b0, mk(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    step("first_move", 1'b1, 1'b0, mk(9'h020, 3'd0, 3'd0, 2'b00, 1'b0));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
